// File: rtl/dem_pkg.sv
// Shared types and helpers for the tree-structured DEM encoder:
// switching-mode enum, LFSR constants, and the root switching-value encoding.
package dem_pkg;

  typedef enum logic [1:0] {
    DEM_DET  = 2'b00,
    DEM_RAND = 2'b01,
    DEM_NS   = 2'b10
  } dem_mode_e;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] DEM_LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEM_SEED_DEFAULT = 16'hACE1;

  function automatic dem_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return DEM_DET;
      2'b01:   return DEM_RAND;
      default: return DEM_NS;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? DEM_LFSR_POLY : 16'h0000);
  endfunction

  // Two's-complement s: 00 for even levels, 01 for +1, 11 for -1.
  function automatic logic [1:0] s_encode(input logic odd, input logic up);
    if (!odd) return 2'b00;
    return up ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/dem_switch_block.sv
// One DEM switching block: splits level x (0..N) into upper/lower halves and
// keeps the 1-bit noise-shaping state used when x is odd.
module dem_switch_block
  import dem_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  dem_mode_e            mode_i,
  input  logic                 rand_bit_i,
  input  logic [$clog2(N):0]   x_i,
  output logic [$clog2(N)-1:0] top_o,
  output logic [$clog2(N)-1:0] bot_o
);

  localparam int XW = $clog2(N) + 1;

  logic odd;
  logic up;
  logic b_q;

  assign odd = x_i[0];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    up = 1'b1;
    case (mode_i)
      DEM_RAND: up = rand_bit_i;
      DEM_NS:   up = ~b_q;
      default:  up = 1'b1;
    endcase
  end

  // (x + s)/2 and (x - s)/2: halve x and give the odd leftover to one side.
  assign top_o = x_i[XW-1:1] + (XW-1)'(odd & up);
  assign bot_o = x_i[XW-1:1] + (XW-1)'(odd & ~up);

  // NOTE: state elements use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_q <= 1'b0;
    end else if (valid_i && odd && (mode_i == DEM_NS)) begin
      b_q <= ~b_q;
    end
  end

endmodule

// File: rtl/dem_tree_encoder.sv
// Tree DEM encoder: maps level x_in onto 2^LAYERS unit-element enables through
// LAYERS layers of switching blocks, one pipeline register per layer.
module dem_tree_encoder
  import dem_pkg::*;
#(
  parameter int          LAYERS = 4,
  parameter int          IN_W   = LAYERS + 1,
  parameter logic [15:0] SEED   = DEM_SEED_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          x_in,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  output logic [(1 << LAYERS)-1:0] out_elem,
  output logic [1:0]               s_out,
  output logic                     sat
);

  localparam int              NE       = 1 << LAYERS;
  localparam logic [IN_W-1:0] NE_LVL   = IN_W'(NE);
  localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_d;
  logic            x_sat;
  logic [IN_W-1:0] x_clamp;

  assign x_sat   = (x_in > NE_LVL);
  assign x_clamp = x_sat ? NE_LVL : x_in;
  assign lfsr_d  = lfsr_step(lfsr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED_EFF;
    end else if (in_valid) begin
      lfsr_q <= lfsr_d;
    end
  end

  // Layer k: 2^k blocks of NE>>k elements; random bits are re-based per layer
  // so bit 0 of rnd_in belongs to heap index 2^k - 1.
  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    localparam int NB = 1 << k;
    localparam int XW = LAYERS - k + 1;
    localparam int RW = NE - NB;

    logic          v_in;
    dem_mode_e     mode_in;
    logic          sat_in;
    logic [1:0]    s_root_in;
    logic [RW-1:0] rnd_in;
    logic [XW-1:0] x_blk [NB];
    logic [XW-2:0] lvl_d [2*NB];
    logic          valid_q;
    logic          sat_q;
    logic [1:0]    s_root_q;

    if (k == 0) begin : g_head
      assign v_in      = in_valid;
      assign mode_in   = decode_mode(mode);
      assign sat_in    = x_sat;
      assign rnd_in    = lfsr_q[NE-2:0];
      assign x_blk[0]  = x_clamp;
      assign s_root_in = s_encode(lvl_d[0] != lvl_d[1], lvl_d[0] > lvl_d[1]);
    end else begin : g_body
      assign v_in      = g_layer[k-1].valid_q;
      assign mode_in   = g_layer[k-1].g_fwd.mode_q;
      assign sat_in    = g_layer[k-1].sat_q;
      assign rnd_in    = g_layer[k-1].g_fwd.rnd_q;
      assign s_root_in = g_layer[k-1].s_root_q;
      for (genvar i = 0; i < NB; i++) begin : g_x
        assign x_blk[i] = g_layer[k-1].g_fwd.lvl_q[i];
      end
    end

    for (genvar i = 0; i < NB; i++) begin : g_blk
      dem_switch_block #(.N(NE >> k)) u_sw (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (v_in),
        .mode_i     (mode_in),
        .rand_bit_i (rnd_in[i]),
        .x_i        (x_blk[i]),
        .top_o      (lvl_d[2*i]),
        .bot_o      (lvl_d[2*i+1])
      );
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q  <= 1'b0;
        sat_q    <= 1'b0;
        s_root_q <= 2'b00;
      end else begin
        valid_q <= v_in;
        if (v_in) begin
          sat_q    <= sat_in;
          s_root_q <= s_root_in;
        end
      end
    end

    if (k < LAYERS - 1) begin : g_fwd
      dem_mode_e        mode_q;
      logic [RW-NB-1:0] rnd_q;
      logic [XW-2:0]    lvl_q [2*NB];

      // NOTE: this register array is reset explicitly, element by element, so a
      // reset leaves no stale levels behind; plain storage arrays would skip it.
      always_ff @(posedge clk) begin
        if (reset) begin
          mode_q <= DEM_DET;
          rnd_q  <= '0;
          for (int i = 0; i < 2*NB; i++) lvl_q[i] <= '0;
        end else if (v_in) begin
          mode_q <= mode_in;
          rnd_q  <= rnd_in[RW-1:NB];
          for (int i = 0; i < 2*NB; i++) lvl_q[i] <= lvl_d[i];
        end
      end
    end else begin : g_out
      logic [NE-1:0] elem_d;
      logic [NE-1:0] elem_q;

      // Leaf 0 is the top-most element.
      for (genvar m = 0; m < NE; m++) begin : g_pack
        assign elem_d[NE-1-m] = lvl_d[m][0];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          elem_q <= '0;
        end else if (v_in) begin
          elem_q <= elem_d;
        end
      end
    end
  end

  assign out_valid = g_layer[LAYERS-1].valid_q;
  assign out_elem  = g_layer[LAYERS-1].g_out.elem_q;
  assign s_out     = g_layer[LAYERS-1].s_root_q;
  assign sat       = g_layer[LAYERS-1].sat_q;

endmodule

// File: tb/tb_dem_tree_encoder.sv
// Scoreboard bench for dem_tree_encoder (LAYERS = 4): the driver queues expected
// responses, a negedge monitor pops and compares whenever out_valid is high.
module tb_dem_tree_encoder;

  localparam int LAYERS = 4;
  localparam int NE     = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  x_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic [15:0] out_elem;
  logic [1:0]  s_out;
  logic        sat;

  dem_tree_encoder #(.LAYERS(LAYERS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_elem  (out_elem),
    .s_out     (s_out),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] elem;
    logic [1:0]  s;
    logic        sat;
    int          pop;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] lfsr_m;
  bit          ns_b [NE-1];
  bit          track_s = 0;
  int          n_pos = 0;
  int          n_neg = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Heap-ordered reference: node j splits into 2j+1 (upper) and 2j+2 (lower).
  task automatic model(input int xc, input logic [1:0] m, input logic [15:0] rb,
                       output logic [15:0] elem, output logic [1:0] s_root);
    int lv [2*NE-1];
    int s;
    lv[0]  = xc;
    s_root = 2'b00;
    elem   = '0;
    for (int j = 0; j < NE-1; j++) begin
      s = 0;
      if (lv[j] % 2 == 1) begin
        case (m)
          2'b00: s = 1;
          2'b01: s = rb[j] ? 1 : -1;
          default: begin
            s = ns_b[j] ? -1 : 1;
            ns_b[j] = !ns_b[j];
          end
        endcase
      end
      if (j == 0) s_root = (s == 1) ? 2'b01 : ((s == -1) ? 2'b11 : 2'b00);
      lv[2*j+1] = (lv[j] + s) / 2;
      lv[2*j+2] = (lv[j] - s) / 2;
    end
    for (int leaf = 0; leaf < NE; leaf++) elem[NE-1-leaf] = (lv[NE-1+leaf] != 0);
  endtask

  task automatic send(input int x, input logic [1:0] m, input bit hand,
                      input logic [15:0] h_elem, input logic [1:0] h_s);
    exp_t        e;
    logic [15:0] elem;
    logic [1:0]  s;
    int          xc;
    xc = (x > NE) ? NE : x;
    model(xc, m, lfsr_m, elem, s);
    lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    e.elem = hand ? h_elem : elem;
    e.s    = hand ? h_s : s;
    e.sat  = (x > NE);
    e.pop  = xc;
    e.due  = cyc + LAYERS;
    sb.push_back(e);
    in_valid = 1'b1;
    x_in     = 5'(x);
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic model_reset();
    lfsr_m = 16'hACE1;
    foreach (ns_b[i]) ns_b[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() != 0 && sb[0].due < cyc) begin
        check("output_overdue", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("latency", cyc, mon_e.due);
          check("out_elem", out_elem, mon_e.elem);
          check("popcount", $countones(out_elem), mon_e.pop);
          check("s_out", s_out, mon_e.s);
          check("sat", sat, mon_e.sat);
          if (track_s) begin
            if (s_out == 2'b01) n_pos++;
            if (s_out == 2'b11) n_neg++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; x_in = '0; mode = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_elem", out_elem, 16'h0000);
    check("rst_s_out", s_out, 2'b00);
    check("rst_sat", sat, 1'b0);
    @(posedge clk); #1;

    // Deterministic single pulse, then a bubble must hold out_elem.
    send(5, 2'b00, 1, 16'hA888, 2'b01);
    drain();
    idle(2);
    @(negedge clk);
    check("bubble_valid", out_valid, 1'b0);
    check("bubble_hold", out_elem, 16'hA888);
    @(posedge clk); #1;

    // Noise-shaped x=1, back to back.
    send(1, 2'b10, 1, 16'h8000, 2'b01);
    send(1, 2'b10, 1, 16'h0080, 2'b11);
    send(1, 2'b10, 1, 16'h0800, 2'b01);
    drain();

    // Clamp boundaries.
    send(31, 2'b00, 1, 16'hFFFF, 2'b00);
    send(16, 2'b00, 1, 16'hFFFF, 2'b00);
    send(0,  2'b00, 1, 16'h0000, 2'b00);
    drain();

    // Reset two cycles after a pulse, with in_valid also high in the reset cycle.
    send(5, 2'b00, 1, 16'hA888, 2'b01);
    idle(1);
    reset = 1'b1; in_valid = 1'b1; x_in = 5'd5; mode = 2'b00;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_elem", out_elem, 16'h0000);
    end
    @(posedge clk); #1;
    send(1, 2'b10, 1, 16'h8000, 2'b01);
    drain();

    // Random mode, x=7, 1000 samples; then repeat after reset.
    do_reset();
    track_s = 1'b1;
    repeat (1000) send(7, 2'b01, 0, 16'h0000, 2'b00);
    drain();
    track_s = 1'b0;
    check("rand_s_pos_seen", n_pos > 0, 1'b1);
    check("rand_s_neg_seen", n_neg > 0, 1'b1);
    check("rand_s_total", n_pos + n_neg, 1000);
    do_reset();
    repeat (64) send(7, 2'b01, 0, 16'h0000, 2'b00);
    drain();

    // Mixed modes, levels 0..20, random gaps.
    repeat (200) begin
      send($urandom_range(0, 20), 2'($urandom_range(0, 3)), 0, 16'h0000, 2'b00);
      idle($urandom_range(0, 2));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
